fp_div_seq: RTL and testbench

Sequential IEEE-754 single-precision divider; the inverse-direction companion to the team's floating-point multiplier on the same datapath.
- Computes result = dataa / datab using a radix-2 restoring mantissa divider, one quotient bit per clock, with round-to-nearest-even.
- Start/busy/done handshake; one operation in flight.
- Sits beside the multiplier in the arithmetic unit; the same controller issues operands to both.

---
 rtl/fp_pkg.sv | 49 ++++
 rtl/fp_mant_div_step.sv | 23 ++
 rtl/fp_div_seq.sv | 208 ++++++++++++++++++++
 tb/tb_fp_div_seq.sv | 247 ++++++++++++++++++++++++
 4 files changed

// File: rtl/fp_pkg.sv
// Shared floating-point definitions for the arithmetic unit (divider and multiplier).
package fp_pkg;

   localparam int              QBITS     = 26;
   localparam logic [4:0]      QCNT_LAST = 5'(QBITS - 1);
   localparam logic signed [9:0] EXP_BIAS = 10'sd127;
   localparam int              FRAC_W    = 23;
   localparam int              EXP_W     = 8;
   localparam logic [31:0]     QNAN      = 32'h7FC0_0000;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      DIV  = 2'd1,
      RND  = 2'd2
   } div_state_e;

   typedef enum logic [1:0] {
      FP_ZERO   = 2'd0,
      FP_INF    = 2'd1,
      FP_NAN    = 2'd2,
      FP_NORMAL = 2'd3
   } fp_class_e;

   // Result override decided at accept time; SPC_NONE means "use the computed quotient".
   typedef enum logic [1:0] {
      SPC_NONE = 2'd0,
      SPC_NAN  = 2'd1,
      SPC_INF  = 2'd2,
      SPC_ZERO = 2'd3
   } spc_kind_e;

   // Operand class with flush-to-zero: a zero exponent (zero or denormal) counts as zero.
   function automatic fp_class_e fp_classify(input logic [31:0] x);
      fp_class_e c;
      if (x[FRAC_W+EXP_W-1:FRAC_W] == 8'h00) begin
         c = FP_ZERO;
      end else if (x[FRAC_W+EXP_W-1:FRAC_W] == 8'hFF) begin
         if (x[FRAC_W-1:0] == 23'h0) begin
            c = FP_INF;
         end else begin
            c = FP_NAN;
         end
      end else begin
         c = FP_NORMAL;
      end
      return c;
   endfunction

endpackage

// File: rtl/fp_mant_div_step.sv
// One restoring division step: compare/subtract, then shift the partial remainder.
module fp_mant_div_step (
   input  logic [25:0] rem,
   input  logic [23:0] mb,
   output logic [25:0] rem_next,
   output logic        qbit
);

   logic [24:0] diff_s;

   // Subtract the divisor when it fits; the remainder leaves this step already doubled.
   always_comb begin
      diff_s = rem[24:0] - {1'b0, mb};
      if (rem >= {2'b00, mb}) begin
         qbit     = 1'b1;
         rem_next = {diff_s, 1'b0};
      end else begin
         qbit     = 1'b0;
         rem_next = {rem[24:0], 1'b0};
      end
   end

endmodule

// File: rtl/fp_div_seq.sv
// Sequential IEEE-754 single-precision divider, one quotient bit per clock, RNE rounding.
// Optional macro FPDIV_FLAGS_EN adds flags[4:0] = {invalid, divzero, overflow, underflow, inexact}.
module fp_div_seq
   import fp_pkg::*;
(
   input  logic        clock,
   input  logic        reset_n,
   input  logic        start,
   input  logic [31:0] dataa,
   input  logic [31:0] datab,
   output logic        busy,
   output logic        done,
   output logic [31:0] result
`ifdef FPDIV_FLAGS_EN
   ,
   output logic [4:0]  flags
`endif
);

   div_state_e          state_r, state_s;
   logic [4:0]          cnt_r;
   logic [25:0]         rem_r, rem_next_s;
   logic [23:0]         mb_r;
   logic [25:0]         q_r;
   logic                qbit_s;
   logic signed [9:0]   exp_r, e_norm_s, e_fin_s;
   logic                sign_r;
   spc_kind_e           spc_r, spc_in_s;
   fp_class_e           cls_a_s, cls_b_s;
   logic                busy_r, done_r;
   logic [31:0]         result_r, result_s;
   logic [23:0]         sig_s;
   logic [24:0]         sum_s;
   logic [22:0]         frac_s;
   logic                guard_s, sticky_s, rnd_up_s, ovf_s, unf_s;
`ifdef FPDIV_FLAGS_EN
   logic                dz_r, dz_in_s;
   logic [4:0]          flags_r, flags_s;
`endif

   // The remainder register holds the already-doubled partial remainder, so it starts at ma.
   fp_mant_div_step u_step (
      .rem      (rem_r),
      .mb       (mb_r),
      .rem_next (rem_next_s),
      .qbit     (qbit_s)
   );

   // Special-operand classification at accept; iterations still run, RND overrides.
   always_comb begin
      cls_a_s  = fp_classify(dataa);
      cls_b_s  = fp_classify(datab);
      spc_in_s = SPC_NONE;
`ifdef FPDIV_FLAGS_EN
      dz_in_s  = 1'b0;
`endif
      if (cls_a_s == FP_NAN || cls_b_s == FP_NAN ||
          (cls_a_s == FP_ZERO && cls_b_s == FP_ZERO) ||
          (cls_a_s == FP_INF && cls_b_s == FP_INF)) begin
         spc_in_s = SPC_NAN;
      end else if (cls_a_s == FP_INF) begin
         spc_in_s = SPC_INF;
      end else if (cls_b_s == FP_ZERO) begin
         spc_in_s = SPC_INF;
`ifdef FPDIV_FLAGS_EN
         dz_in_s  = 1'b1;
`endif
      end else if (cls_a_s == FP_ZERO || cls_b_s == FP_INF) begin
         spc_in_s = SPC_ZERO;
      end else begin
         spc_in_s = SPC_NONE;
      end
   end

   // Next-state logic: IDLE -> DIV on start, DIV for QBITS steps, RND for one cycle.
   always_comb begin
      state_s = state_r;
      case (state_r)
         IDLE:    if (start) state_s = DIV; else state_s = IDLE;
         DIV:     if (cnt_r == QCNT_LAST) state_s = RND; else state_s = DIV;
         RND:     state_s = IDLE;
         default: state_s = IDLE;
      endcase
   end

   // Normalise, round-to-nearest-even and pack the quotient.
   always_comb begin
      if (q_r[25]) begin
         sig_s    = q_r[25:2];
         guard_s  = q_r[1];
         sticky_s = q_r[0] | (rem_r != 26'd0);
         e_norm_s = exp_r;
      end else begin
         sig_s    = q_r[24:1];
         guard_s  = q_r[0];
         sticky_s = (rem_r != 26'd0);
         e_norm_s = exp_r - 10'sd1;
      end
      rnd_up_s = guard_s & (sticky_s | sig_s[0]);
      sum_s    = {1'b0, sig_s} + {24'd0, rnd_up_s};
      if (sum_s[24]) begin
         frac_s  = sum_s[23:1];
         e_fin_s = e_norm_s + 10'sd1;
      end else begin
         frac_s  = sum_s[22:0];
         e_fin_s = e_norm_s;
      end
      ovf_s = (e_fin_s >= 10'sd255);
      unf_s = (e_fin_s <= 10'sd0);
      case (spc_r)
         SPC_NAN:  result_s = QNAN;
         SPC_INF:  result_s = {sign_r, 8'hFF, 23'h0};
         SPC_ZERO: result_s = {sign_r, 31'h0};
         default: begin
            if (ovf_s) begin
               result_s = {sign_r, 8'hFF, 23'h0};
            end else if (unf_s) begin
               result_s = {sign_r, 31'h0};
            end else begin
               result_s = {sign_r, e_fin_s[7:0], frac_s};
            end
         end
      endcase
   end

`ifdef FPDIV_FLAGS_EN
   // Exception flags; computed-result flags apply only when no special override is active.
   always_comb begin
      if (spc_r == SPC_NONE) begin
         flags_s = {1'b0, 1'b0, ovf_s, unf_s & ~ovf_s, ovf_s | unf_s | guard_s | sticky_s};
      end else begin
         flags_s = {spc_r == SPC_NAN, dz_r, 3'b000};
      end
   end
`endif

   // FSM state register.
   always_ff @(posedge clock or negedge reset_n) begin
      if (!reset_n) begin
         state_r <= IDLE;
      end else begin
         state_r <= state_s;
      end
   end

   // Datapath and registered handshake/result outputs.
   always_ff @(posedge clock or negedge reset_n) begin
      if (!reset_n) begin
         cnt_r    <= 5'd0;
         rem_r    <= 26'd0;
         mb_r     <= 24'd0;
         q_r      <= 26'd0;
         exp_r    <= 10'sd0;
         sign_r   <= 1'b0;
         spc_r    <= SPC_NONE;
         busy_r   <= 1'b0;
         done_r   <= 1'b0;
         result_r <= 32'h0;
`ifdef FPDIV_FLAGS_EN
         dz_r     <= 1'b0;
         flags_r  <= 5'd0;
`endif
      end else begin
         done_r <= 1'b0;
         case (state_r)
            IDLE: begin
               if (start) begin
                  sign_r <= dataa[31] ^ datab[31];
                  exp_r  <= $signed({2'b00, dataa[30:23]}) - $signed({2'b00, datab[30:23]}) + EXP_BIAS;
                  rem_r  <= {3'b001, dataa[22:0]};
                  mb_r   <= {1'b1, datab[22:0]};
                  q_r    <= 26'd0;
                  cnt_r  <= 5'd0;
                  spc_r  <= spc_in_s;
                  busy_r <= 1'b1;
`ifdef FPDIV_FLAGS_EN
                  dz_r   <= dz_in_s;
`endif
               end
            end
            DIV: begin
               rem_r <= rem_next_s;
               q_r   <= {q_r[24:0], qbit_s};
               cnt_r <= cnt_r + 5'd1;
            end
            RND: begin
               result_r <= result_s;
               done_r   <= 1'b1;
               busy_r   <= 1'b0;
`ifdef FPDIV_FLAGS_EN
               flags_r  <= flags_s;
`endif
            end
            default: begin
               busy_r <= 1'b0;
            end
         endcase
      end
   end

   assign busy   = busy_r;
   assign done   = done_r;
   assign result = result_r;
`ifdef FPDIV_FLAGS_EN
   assign flags  = flags_r;
`endif

endmodule

// File: tb/tb_fp_div_seq.sv
// Self-checking bench for fp_div_seq: directed vectors, random operands against a
// double-precision reference, handshake corner cases and mid-operation reset.
module tb_fp_div_seq;

   logic        clock = 1'b0;
   logic        reset_n = 1'b0;
   logic        start = 1'b0;
   logic [31:0] dataa = 32'h0;
   logic [31:0] datab = 32'h0;
   logic        busy, done;
   logic [31:0] result;
`ifdef FPDIV_FLAGS_EN
   logic [4:0]  flags;
`endif

   int chk_cnt  = 0;
   int pass_cnt = 0;

   always #5 clock = ~clock;

   fp_div_seq dut (
      .clock   (clock),
      .reset_n (reset_n),
      .start   (start),
      .dataa   (dataa),
      .datab   (datab),
      .busy    (busy),
      .done    (done),
      .result  (result)
`ifdef FPDIV_FLAGS_EN
      ,
      .flags   (flags)
`endif
   );

   // Reference: specials by rule, otherwise exact-enough double quotient rounded to single.
   function automatic logic [31:0] ref_div(input logic [31:0] a, input logic [31:0] b);
      logic        s, a_zero, b_zero, a_inf, b_inf, a_nan, b_nan;
      real         da, db;
      logic [63:0] dq;
      int          e;
      logic [23:0] fr;
      s      = a[31] ^ b[31];
      a_zero = (a[30:23] == 8'h00);
      b_zero = (b[30:23] == 8'h00);
      a_inf  = (a[30:23] == 8'hFF) && (a[22:0] == 23'h0);
      b_inf  = (b[30:23] == 8'hFF) && (b[22:0] == 23'h0);
      a_nan  = (a[30:23] == 8'hFF) && (a[22:0] != 23'h0);
      b_nan  = (b[30:23] == 8'hFF) && (b[22:0] != 23'h0);
      if (a_nan || b_nan || (a_zero && b_zero) || (a_inf && b_inf)) return 32'h7FC0_0000;
      if (a_inf)  return {s, 8'hFF, 23'h0};
      if (b_zero) return {s, 8'hFF, 23'h0};
      if (a_zero || b_inf) return {s, 31'h0};
      da = $bitstoreal({1'b0, {3'b000, a[30:23]} + 11'd896, a[22:0], 29'h0});
      db = $bitstoreal({1'b0, {3'b000, b[30:23]} + 11'd896, b[22:0], 29'h0});
      dq = $realtobits(da / db);
      e  = int'(dq[62:52]) - 896;
      fr = {1'b0, dq[51:29]};
      if (dq[28] && ((|dq[27:0]) || dq[29])) begin
         fr = fr + 24'd1;
         if (fr[23]) e = e + 1;
      end
      if (e >= 255) return {s, 8'hFF, 23'h0};
      if (e <= 0)   return {s, 31'h0};
      return {s, 8'(e), fr[22:0]};
   endfunction

   function automatic logic [31:0] rand_operand();
      logic [31:0] x;
      int          k;
      k = $urandom_range(0, 9);
      x = $urandom;
      if (k == 0) begin
         case ($urandom_range(0, 5))
            0:       x = 32'h0000_0000;
            1:       x = 32'h8000_0000;
            2:       x = 32'h7F80_0000;
            3:       x = 32'hFF80_0000;
            4:       x = 32'h7FC0_0001;
            default: x[30:23] = 8'h00;
         endcase
      end else if (k <= 6) begin
         x[30:23] = 8'($urandom_range(100, 154));
      end else begin
         x[30:23] = 8'($urandom_range(1, 254));
      end
      return x;
   endfunction

   // Issue one operation from an idle DUT and wait (bounded) for its done pulse.
   // Returns with time at #1 after the edge that raised done, i.e. inside the done cycle.
   task automatic run_op(input logic [31:0] a, input logic [31:0] b,
                         output logic [31:0] res, output int lat,
                         output logic busy_ok, output logic busy_at_done);
      res = 32'h0; lat = -1; busy_ok = 1'b1; busy_at_done = 1'b1;
      start = 1'b1; dataa = a; datab = b;
      @(posedge clock); #1;
      start = 1'b0;
      if (busy !== 1'b1) busy_ok = 1'b0;
      for (int n = 1; n <= 60; n++) begin
         @(posedge clock); #1;
         if (done === 1'b1) begin
            lat = n; res = result; busy_at_done = busy;
            break;
         end
         if (busy !== 1'b1) busy_ok = 1'b0;
      end
   endtask

   task automatic test_reset();
      reset_n = 1'b0;
      repeat (3) @(posedge clock);
      #1;
      chk_cnt++; if (busy !== 1'b0) $display("FAIL reset_busy got=%b want=0", busy); else pass_cnt++;
      chk_cnt++; if (done !== 1'b0) $display("FAIL reset_done got=%b want=0", done); else pass_cnt++;
      chk_cnt++; if (result !== 32'h0) $display("FAIL reset_result got=%h want=00000000", result); else pass_cnt++;
      reset_n = 1'b1;
      @(posedge clock); #1;
      chk_cnt++; if (busy !== 1'b0 || done !== 1'b0) $display("FAIL post_reset_idle busy=%b done=%b want 0/0", busy, done); else pass_cnt++;
   endtask

   // Spec vectors; the 27 edges after the accept edge place done in the 28th cycle.
   task automatic test_directed();
      logic [31:0] va [7] = '{32'h40C00000, 32'h3F800000, 32'h3F800000, 32'h00000000,
                              32'hBF800000, 32'h7F7FFFFF, 32'h00800000};
      logic [31:0] vb [7] = '{32'h40000000, 32'h40400000, 32'h00000000, 32'h00000000,
                              32'h7F800000, 32'h3F000000, 32'h40000000};
      logic [31:0] ve [7] = '{32'h40400000, 32'h3EAAAAAB, 32'h7F800000, 32'h7FC00000,
                              32'h80000000, 32'h7F800000, 32'h00000000};
`ifdef FPDIV_FLAGS_EN
      logic [4:0]  vf [7] = '{5'b00000, 5'b00001, 5'b01000, 5'b10000,
                              5'b00000, 5'b00101, 5'b00011};
`endif
      logic [31:0] res;
      int          lat;
      logic        bok, bdone;
      for (int i = 0; i < 7; i++) begin
         run_op(va[i], vb[i], res, lat, bok, bdone);
         chk_cnt++;
         if (res !== ve[i]) $display("FAIL directed_result[%0d] %h/%h got=%h want=%h", i, va[i], vb[i], res, ve[i]);
         else pass_cnt++;
         chk_cnt++;
         if (lat !== 27) $display("FAIL directed_latency[%0d] got=%0d edges want=27", i, lat);
         else pass_cnt++;
         chk_cnt++;
         if (bok !== 1'b1 || bdone !== 1'b0) $display("FAIL directed_busy[%0d] busy_between=%b busy_at_done=%b want 1/0", i, bok, bdone);
         else pass_cnt++;
`ifdef FPDIV_FLAGS_EN
         chk_cnt++;
         if (flags !== vf[i]) $display("FAIL directed_flags[%0d] got=%b want=%b", i, flags, vf[i]);
         else pass_cnt++;
`endif
      end
   endtask

   task automatic test_random();
      logic [31:0] a, b, res, exp_res;
      int          lat;
      logic        bok, bdone;
      for (int i = 0; i < 60; i++) begin
         a = rand_operand();
         b = rand_operand();
         exp_res = ref_div(a, b);
         run_op(a, b, res, lat, bok, bdone);
         chk_cnt++;
         if (res !== exp_res || lat !== 27) $display("FAIL random[%0d] %h/%h got=%h lat=%0d want=%h lat=27", i, a, b, res, lat, exp_res);
         else pass_cnt++;
      end
   endtask

   task automatic test_ignore_start();
      int          ndone;
      int          done_at;
      logic [31:0] res;
      ndone = 0; done_at = -1; res = 32'h0;
      start = 1'b1; dataa = 32'h40C00000; datab = 32'h40000000;
      @(posedge clock); #1;
      start = 1'b0;
      for (int n = 1; n <= 60; n++) begin
         @(posedge clock); #1;
         if (done === 1'b1) begin
            ndone++; done_at = n; res = result;
         end
         if (n == 4) begin
            start = 1'b1; dataa = 32'h3F800000; datab = 32'h40400000;
         end
         if (n == 5) start = 1'b0;
      end
      chk_cnt++; if (ndone !== 1) $display("FAIL ignore_done_count got=%0d want=1", ndone); else pass_cnt++;
      chk_cnt++; if (done_at !== 27) $display("FAIL ignore_latency got=%0d want=27", done_at); else pass_cnt++;
      chk_cnt++; if (res !== 32'h40400000) $display("FAIL ignore_result got=%h want=40400000", res); else pass_cnt++;
   endtask

   task automatic test_back_to_back();
      logic [31:0] r1, r2;
      int          l1, l2;
      logic        b1, b2, d1, d2;
      run_op(32'h40C00000, 32'h40000000, r1, l1, b1, d1);
      // Next start is raised inside the done cycle and taken on the following edge.
      run_op(32'h3F800000, 32'h40400000, r2, l2, b2, d2);
      chk_cnt++; if (r1 !== 32'h40400000) $display("FAIL b2b_first got=%h want=40400000", r1); else pass_cnt++;
      chk_cnt++; if (r2 !== 32'h3EAAAAAB) $display("FAIL b2b_second got=%h want=3EAAAAAB", r2); else pass_cnt++;
      chk_cnt++; if (l2 !== 27 || b2 !== 1'b1) $display("FAIL b2b_second_timing lat=%0d busy=%b want 27/1", l2, b2); else pass_cnt++;
   endtask

   task automatic test_reset_mid();
      logic [31:0] res;
      int          lat, ndone;
      logic        bok, bdone;
      run_op(32'h40C00000, 32'h40000000, res, lat, bok, bdone);
      chk_cnt++; if (res !== 32'h40400000) $display("FAIL rstmid_pre got=%h want=40400000", res); else pass_cnt++;
      @(posedge clock); #1;
      start = 1'b1; dataa = 32'h3F800000; datab = 32'h40400000;
      @(posedge clock); #1;
      start = 1'b0;
      repeat (10) @(posedge clock);
      #1;
      reset_n = 1'b0;
      #1;
      chk_cnt++;
      if (busy !== 1'b0 || done !== 1'b0 || result !== 32'h0)
         $display("FAIL rstmid_clear busy=%b done=%b result=%h want 0/0/00000000", busy, done, result);
      else pass_cnt++;
      @(posedge clock); #1;
      reset_n = 1'b1;
      ndone = 0;
      for (int n = 0; n < 60; n++) begin
         @(posedge clock); #1;
         if (done === 1'b1 || busy === 1'b1) ndone++;
      end
      chk_cnt++; if (ndone !== 0) $display("FAIL rstmid_no_done got=%0d active cycles want=0", ndone); else pass_cnt++;
      run_op(32'hC0C00000, 32'h40000000, res, lat, bok, bdone);
      chk_cnt++; if (res !== 32'hC0400000 || lat !== 27) $display("FAIL rstmid_recover got=%h lat=%0d want=C0400000 lat=27", res, lat); else pass_cnt++;
   endtask

   initial begin
      test_reset();
      test_directed();
      test_random();
      test_ignore_start();
      test_back_to_back();
      test_reset_mid();
      $display("%0d/%0d checks passed", pass_cnt, chk_cnt);
      $finish;
   end

endmodule
